// File: rtl/lfsr16_prbs_checker.sv
// Receive-side checker for the 16-bit LFSR word stream (taps 15,14,12,3).
// Self-synchronises, flywheels its own reference once locked, and counts word/bit errors.
module lfsr16_prbs_checker #(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 8,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [15:0]      rx_data,
    input  logic             clear_counts,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_err_count,
    output logic             state_dbg
);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int UW = $clog2(UNLOCK_COUNT + 1);
    localparam int SW = CNT_W + 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [15:0]      ref_q, ref_d;
    logic             ref_valid_q, ref_valid_d;
    logic [MW-1:0]    match_q, match_d;
    logic [UW-1:0]    miss_q, miss_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    logic [15:0]      expected;
    logic [4:0]       diff_bits;
    logic [SW-1:0]    bit_sum;
    logic [MW-1:0]    match_inc;
    logic [UW-1:0]    miss_inc;

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[14] ^ x[12] ^ x[3]};
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'b0000, v[i]};
        end
        return n;
    endfunction

    always_comb begin
        expected  = lfsr_next(ref_q);
        diff_bits = popcount16(rx_data ^ expected);
        bit_sum   = SW'(bit_cnt_q) + SW'(diff_bits);
        match_inc = match_q + MW'(1);
        miss_inc  = miss_q + UW'(1);
    end

    always_comb begin
        state_d     = state_q;
        ref_d       = ref_q;
        ref_valid_d = ref_valid_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        bit_cnt_d   = bit_cnt_q;

        if (enable) begin
            case (state_q)
                SEARCH: begin
                    // All-zero is the LFSR lock-up word, so it can never act as a seed.
                    if (rx_data == 16'h0000) begin
                        ref_valid_d = 1'b0;
                        match_d     = '0;
                    end else if (ref_valid_q && (rx_data == expected)) begin
                        ref_d   = rx_data;
                        match_d = match_inc;
                        if (match_inc == MW'(LOCK_COUNT)) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        ref_d       = rx_data;
                        ref_valid_d = 1'b1;
                        match_d     = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the reference advances on its own, so a corrupt word costs one error.
                    ref_d = expected;
                    if (rx_data == expected) begin
                        miss_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        miss_d      = miss_inc;
                        if (err_cnt_q != CNT_MAX) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
                        if (bit_sum > SW'(CNT_MAX)) begin
                            bit_cnt_d = CNT_MAX;
                        end else begin
                            bit_cnt_d = bit_sum[CNT_W-1:0];
                        end
                        if (miss_inc == UW'(UNLOCK_COUNT)) begin
                            state_d     = SEARCH;
                            ref_valid_d = 1'b0;
                            match_d     = '0;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        if (clear_counts) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= SEARCH;
            ref_q       <= '0;
            ref_valid_q <= 1'b0;
            match_q     <= '0;
            miss_q      <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            ref_valid_q <= ref_valid_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    assign locked        = (state_q == LOCKED);
    assign state_dbg     = state_q;
    assign err_pulse     = err_pulse_q;
    assign err_count     = err_cnt_q;
    assign bit_err_count = bit_cnt_q;

endmodule

// File: tb/tb_lfsr16_prbs_checker.sv
// Directed bench for lfsr16_prbs_checker: acquisition, flywheel errors, clear,
// unlock/relock, reset, zero stream, and counter saturation on a narrow instance.
module tb_lfsr16_prbs_checker;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [15:0] rx_data;
    logic        clear_counts;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [15:0] bit_err_count;
    logic        state_dbg;

    logic        s_enable;
    logic [15:0] s_rx_data;
    logic        s_clear;
    logic        s_locked;
    logic        s_err_pulse;
    logic [3:0]  s_err_count;
    logic [3:0]  s_bit_err_count;
    logic        s_state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] tx;
    logic [15:0] stx;

    lfsr16_prbs_checker u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .rx_data       (rx_data),
        .clear_counts  (clear_counts),
        .locked        (locked),
        .err_pulse     (err_pulse),
        .err_count     (err_count),
        .bit_err_count (bit_err_count),
        .state_dbg     (state_dbg)
    );

    lfsr16_prbs_checker #(
        .LOCK_COUNT   (4),
        .UNLOCK_COUNT (32),
        .CNT_W        (4)
    ) u_sat (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (s_enable),
        .rx_data       (s_rx_data),
        .clear_counts  (s_clear),
        .locked        (s_locked),
        .err_pulse     (s_err_pulse),
        .err_count     (s_err_count),
        .bit_err_count (s_bit_err_count),
        .state_dbg     (s_state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[14] ^ x[12] ^ x[3]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // driver tasks: one enabled word per call, sampled 1ns after the edge
    task automatic send(input logic [15:0] w, input logic clr);
        @(negedge clk);
        enable       = 1'b1;
        rx_data      = w;
        clear_counts = clr;
        @(posedge clk);
        #1;
        enable       = 1'b0;
        clear_counts = 1'b0;
    endtask

    task automatic send_next(input logic [15:0] flip);
        tx = lfsr_next(tx);
        send(tx ^ flip, 1'b0);
    endtask

    task automatic s_send(input logic [15:0] w);
        @(negedge clk);
        s_enable  = 1'b1;
        s_rx_data = w;
        @(posedge clk);
        #1;
        s_enable  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n      = 1'b0;
        enable       = 1'b0;
        rx_data      = '0;
        clear_counts = 1'b0;
        s_enable     = 1'b0;
        s_rx_data    = '0;
        s_clear      = 1'b0;
        idle(2);
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_errcnt", 32'(err_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // acquisition with enable gaps between words
        tx = 16'hACE1;
        send(tx, 1'b0);
        idle(1);
        send(16'h59C3, 1'b0);
        tx = 16'h59C3;
        idle(2);
        send_next(16'h0000);
        idle(1);
        send_next(16'h0000);
        check("acq_4th_unlocked", 32'(locked), 32'd0);
        idle(3);
        send_next(16'h0000);
        check("acq_5th_locked", 32'(locked), 32'd1);
        check("acq_state_dbg", 32'(state_dbg), 32'd1);
        check("acq_errcnt", 32'(err_count), 32'd0);
        check("acq_pulse", 32'(err_pulse), 32'd0);

        // single-bit error, then clean resume
        send_next(16'h0001);
        check("sbe_pulse", 32'(err_pulse), 32'd1);
        check("sbe_errcnt", 32'(err_count), 32'd1);
        check("sbe_bitcnt", 32'(bit_err_count), 32'd1);
        idle(1);
        check("sbe_pulse_idle", 32'(err_pulse), 32'd0);
        send_next(16'h0000);
        send_next(16'h0000);
        check("sbe_resume_pulse", 32'(err_pulse), 32'd0);
        check("sbe_resume_errcnt", 32'(err_count), 32'd1);
        check("sbe_resume_locked", 32'(locked), 32'd1);

        // full-word burst, then clear coincident with a mismatch
        send_next(16'hFFFF);
        check("burst_errcnt", 32'(err_count), 32'd2);
        check("burst_bitcnt", 32'(bit_err_count), 32'd17);
        tx = lfsr_next(tx);
        send(tx ^ 16'h0101, 1'b1);
        check("clr_errcnt", 32'(err_count), 32'd0);
        check("clr_bitcnt", 32'(bit_err_count), 32'd0);
        check("clr_pulse", 32'(err_pulse), 32'd1);
        check("clr_locked", 32'(locked), 32'd1);
        send_next(16'h0000);
        check("clr_after_errcnt", 32'(err_count), 32'd0);

        // loss of lock: eight garbage words
        for (int i = 0; i < 7; i++) send(16'h1234, 1'b0);
        check("lol_7_locked", 32'(locked), 32'd1);
        check("lol_7_errcnt", 32'(err_count), 32'd7);
        send(16'h1234, 1'b0);
        check("lol_8_locked", 32'(locked), 32'd0);
        check("lol_8_errcnt", 32'(err_count), 32'd8);
        check("lol_8_pulse", 32'(err_pulse), 32'd1);

        // relock from a clean stream; no counting while searching
        tx = 16'hACE1;
        send(tx, 1'b0);
        check("relock_search_pulse", 32'(err_pulse), 32'd0);
        for (int i = 0; i < 3; i++) send_next(16'h0000);
        check("relock_4_unlocked", 32'(locked), 32'd0);
        send_next(16'h0000);
        check("relock_5_locked", 32'(locked), 32'd1);
        check("relock_errcnt", 32'(err_count), 32'd8);

        // asynchronous reset mid-stream while locked, between edges
        send_next(16'h0003);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_locked", 32'(locked), 32'd0);
        check("arst_pulse", 32'(err_pulse), 32'd0);
        check("arst_errcnt", 32'(err_count), 32'd0);
        check("arst_bitcnt", 32'(bit_err_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // all-zero stream must never lock
        for (int i = 0; i < 10; i++) send(16'h0000, 1'b0);
        check("zero_locked", 32'(locked), 32'd0);
        tx = 16'h1D2B;
        send(tx, 1'b0);
        for (int i = 0; i < 3; i++) send_next(16'h0000);
        check("post_zero_4_unlocked", 32'(locked), 32'd0);
        send_next(16'h0000);
        check("post_zero_5_locked", 32'(locked), 32'd1);

        // saturation on the 4-bit counter instance
        stx = 16'hACE1;
        s_send(stx);
        for (int i = 0; i < 4; i++) begin
            stx = lfsr_next(stx);
            s_send(stx);
        end
        check("sat_locked", 32'(s_locked), 32'd1);
        for (int i = 0; i < 15; i++) begin
            stx = lfsr_next(stx);
            s_send(stx ^ 16'h8000);
        end
        check("sat_15_errcnt", 32'(s_err_count), 32'd15);
        for (int i = 0; i < 5; i++) begin
            stx = lfsr_next(stx);
            s_send(stx ^ 16'h0010);
        end
        check("sat_20_errcnt", 32'(s_err_count), 32'd15);
        check("sat_20_bitcnt", 32'(s_bit_err_count), 32'd15);
        check("sat_20_locked", 32'(s_locked), 32'd1);
        check("main_untouched_errcnt", 32'(err_count), 32'd0);

        // report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
